// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage of the 32-bit MIPS-style pipeline.
// Owns the PC, issues word fetches over a req/ack handshake and loads the IF/ID register.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   stall                       decode cannot accept a new instruction
//   redirect, redirect_pc       taken branch/jump and its target (bits [1:0] ignored)
//   imem_req, imem_addr         fetch request and word-aligned address (registered)
//   imem_ack, imem_rdata        memory response (ignored while imem_req is low)
//   id_valid, id_instr          IF/ID live flag and instruction word
//   id_pc_plus4                 fetch address of id_instr plus 4
//   id_opcode/rs/rt/rd/funct    decoded bit fields of id_instr
//   id_imm16                    low half of id_instr, feeds the sign extender
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic [5:0]  id_opcode,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [5:0]  id_funct,
  output logic [15:0] id_imm16
);

  typedef enum logic [1:0] {StFetch, StHold, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc4_q, id_pc4_d;

  logic        ack;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_tgt;

  // An ack only counts against a request we actually presented.
  assign ack          = imem_ack & req_q;
  assign pc_plus4     = pc_q + 32'd4;
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc4_d     = id_pc4_q;

    if (redirect) begin
      // Flush wins over everything, including stall.
      id_valid_d = 1'b0;
      pc_d       = redirect_tgt;
      unique case (state_q)
        StFetch: state_d = (ack || !req_q) ? StFetch : StDrain;
        StDrain: state_d = ack ? StFetch : StDrain;
        default: state_d = StFetch;
      endcase
    end else begin
      unique case (state_q)
        StFetch: begin
          if (ack) begin
            if (stall) begin
              skid_instr_d = imem_rdata;
              skid_pc4_d   = pc_plus4;
              state_d      = StHold;
            end else begin
              id_valid_d = 1'b1;
              id_instr_d = imem_rdata;
              id_pc4_d   = pc_plus4;
              pc_d       = pc_plus4;
            end
          end else if (!stall) begin
            id_valid_d = 1'b0;
          end
        end
        StHold: begin
          if (!stall) begin
            id_valid_d = 1'b1;
            id_instr_d = skid_instr_q;
            id_pc4_d   = skid_pc4_q;
            pc_d       = skid_pc4_q;
            state_d    = StFetch;
          end
        end
        StDrain: begin
          // The returning word belongs to the abandoned path.
          id_valid_d = 1'b0;
          if (ack) state_d = StFetch;
        end
        default: state_d = StFetch;
      endcase
    end

    req_d = (state_d != StHold);
    // The address may only move once the outstanding request has been answered.
    addr_d = (ack || !req_q) ? pc_d : addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      req_q        <= 1'b0;
      skid_instr_q <= 32'd0;
      skid_pc4_q   <= 32'd0;
      id_valid_q   <= 1'b0;
      id_instr_q   <= 32'd0;
      id_pc4_q     <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc4_q     <= id_pc4_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_pc_plus4 = id_pc4_q;
  assign id_opcode   = id_instr_q[31:26];
  assign id_rs       = id_instr_q[25:21];
  assign id_rt       = id_instr_q[20:16];
  assign id_rd       = id_instr_q[15:11];
  assign id_funct    = id_instr_q[5:0];
  assign id_imm16    = id_instr_q[15:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios with an instruction scoreboard.
// Stimulus pushes the expected (instr, pc+4) stream; the monitor pops whenever decode
// consumes an instruction (id_valid high, stall low, reset low) at a falling edge.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr, id_pc_plus4;
  logic [5:0]  id_opcode, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_imm16;

  // Second instance with a wrapping reset PC, fed from the same memory responses.
  logic        d2_req, d2_valid;
  logic [31:0] d2_addr, d2_instr, d2_pc4;
  logic [5:0]  d2_opcode, d2_funct;
  logic [4:0]  d2_rs, d2_rt, d2_rd;
  logic [15:0] d2_imm16;

  int          nvec = 0;
  int          nerr = 0;
  int          mem_wait = 0;
  logic        stray_ack = 1'b0;
  logic [31:0] exp_instr_q[$];
  logic [31:0] exp_pc4_q[$];

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_funct(id_funct), .id_imm16(id_imm16)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(d2_req), .imem_addr(d2_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_valid(d2_valid), .id_instr(d2_instr), .id_pc_plus4(d2_pc4),
    .id_opcode(d2_opcode), .id_rs(d2_rs), .id_rt(d2_rt), .id_rd(d2_rd),
    .id_funct(d2_funct), .id_imm16(d2_imm16)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc4);
    exp_instr_q.push_back(instr);
    exp_pc4_q.push_back(pc4);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    stall    = 1'b0;
    redirect = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h20) ? 32'h8C22_0004 : a;
  endfunction

  // Memory: answers mem_wait cycles after a request appears, data = address.
  initial begin
    int wcnt;
    wcnt       = 0;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      if (stray_ack) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        wcnt       = 0;
      end else if (imem_req) begin
        if (wcnt == mem_wait) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          wcnt       = 0;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 32'h0BAD_0BAD;
          wcnt++;
        end
      end else begin
        imem_ack = 1'b0;
        wcnt     = 0;
      end
    end
  end

  // Monitor: compare every consumed instruction against the scoreboard.
  always @(negedge clk) begin
    logic [31:0] e, ep;
    if (!reset && id_valid && !stall) begin
      if (exp_instr_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL sb_unexpected: got instr %0h pc4 %0h, required none", id_instr,
                 id_pc_plus4);
      end else begin
        e  = exp_instr_q.pop_front();
        ep = exp_pc4_q.pop_front();
        chk("sb_instr", {32'd0, id_instr}, {32'd0, e});
        chk("sb_pc4", {32'd0, id_pc_plus4}, {32'd0, ep});
        chk("sb_fields", {21'd0, id_opcode, id_rs, id_rt, id_rd, id_funct, id_imm16},
            {21'd0, e[31:26], e[25:21], e[20:16], e[15:11], e[5:0], e[15:0]});
      end
    end
  end

  initial begin
    // Reset state.
    mem_wait = 0;
    do_reset();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", id_valid, 0);
    chk("rst_instr", id_instr, 0);
    chk("rst_pc4", id_pc_plus4, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_d2_addr", d2_addr, 32'hFFFF_FFFC);

    // Sequential zero-wait fetch.
    for (int i = 0; i < 4; i++) push(i * 4, i * 4 + 4);
    for (int k = 0; k <= 5; k++) begin
      tick();
      if (k == 0) begin
        chk("seq_req", imem_req, 1);
        chk("seq_addr0", imem_addr, 0);
        chk("wrap_addr0", d2_addr, 32'hFFFF_FFFC);
      end
      if (k == 1) begin
        chk("seq_addr1", imem_addr, 4);
        chk("wrap_addr1", d2_addr, 0);
        chk("wrap_pc4", d2_pc4, 0);
      end
      if (k >= 1) chk("seq_valid", id_valid, 1);
    end
    chk("seq_all_seen", exp_instr_q.size(), 0);

    // Two wait states per fetch.
    mem_wait = 2;
    do_reset();
    for (int i = 0; i < 3; i++) push(i * 4, i * 4 + 4);
    for (int k = 0; k <= 10; k++) begin
      tick();
      if (k <= 2) chk("wait_addr_hold", imem_addr, 0);
      if (k == 3) chk("wait_addr_next", imem_addr, 4);
      if (k >= 1 && k <= 9) chk("wait_valid", id_valid, (k % 3 == 0) ? 1 : 0);
    end
    chk("wait_all_seen", exp_instr_q.size(), 0);

    // Stall while 0x8C220004 returns from address 0x20.
    mem_wait = 0;
    do_reset();
    for (int i = 0; i < 8; i++) push(i * 4, i * 4 + 4);
    push(32'h8C22_0004, 32'h24);
    push(32'h24, 32'h28);
    for (int k = 0; k <= 14; k++) begin
      tick();
      if (k == 8) stall = 1'b1;
      if (k == 11) stall = 1'b0;
      if (k == 9 || k == 10) begin
        chk("stall_req_low", imem_req, 0);
        chk("stall_id_hold", id_instr, 32'h1C);
        chk("stall_valid_hold", id_valid, 1);
      end
      if (k == 12) begin
        chk("stall_rel_instr", id_instr, 32'h8C22_0004);
        chk("stall_rel_imm16", id_imm16, 16'h0004);
        chk("stall_rel_rt", id_rt, 2);
        chk("stall_rel_addr", imem_addr, 32'h24);
        chk("stall_rel_req", imem_req, 1);
      end
    end
    chk("stall_all_seen", exp_instr_q.size(), 0);

    // Redirect with same-cycle ack, then redirect to 0x43 together with stall.
    do_reset();
    push(0, 4);
    push(4, 8);
    push(8, 12);
    push(32'h40, 32'h44);
    push(32'h40, 32'h44);
    for (int k = 0; k <= 9; k++) begin
      tick();
      if (k == 3) begin
        redirect    = 1'b1;
        redirect_pc = 32'h40;
      end
      if (k == 4) begin
        redirect = 1'b0;
        chk("redir_bubble", id_valid, 0);
        chk("redir_addr", imem_addr, 32'h40);
      end
      if (k == 5) chk("redir_target_valid", id_valid, 1);
      if (k == 6) begin
        redirect    = 1'b1;
        redirect_pc = 32'h43;
        stall       = 1'b1;
      end
      if (k == 7) begin
        redirect = 1'b0;
        stall    = 1'b0;
        chk("redir_align_addr", imem_addr, 32'h40);
        chk("redir_stall_flush", id_valid, 0);
        chk("redir_stall_req", imem_req, 1);
      end
    end
    chk("redir_all_seen", exp_instr_q.size(), 0);

    // Redirect while a slow fetch is outstanding, then a second redirect in DRAIN.
    mem_wait = 3;
    do_reset();
    push(0, 4);
    push(32'h80, 32'h84);
    for (int k = 0; k <= 13; k++) begin
      tick();
      if (k == 5) begin
        redirect    = 1'b1;
        redirect_pc = 32'h60;
      end
      if (k == 6) begin
        redirect_pc = 32'h80;
        chk("drain_addr_hold", imem_addr, 4);
        chk("drain_req", imem_req, 1);
      end
      if (k == 7) begin
        redirect = 1'b0;
        chk("drain_addr_hold2", imem_addr, 4);
      end
      if (k == 8) chk("drain_next_addr", imem_addr, 32'h80);
      if (k >= 5 && k <= 11) chk("drain_valid_low", id_valid, 0);
      if (k == 12) chk("drain_target", id_instr, 32'h80);
    end
    chk("drain_all_seen", exp_instr_q.size(), 0);

    // Reset during an outstanding request, then a stray ack.
    mem_wait = 3;
    do_reset();
    push(0, 4);
    for (int k = 0; k <= 8; k++) begin
      tick();
      if (k == 1) reset = 1'b1;
      if (k == 2) begin
        chk("mrst_req_low", imem_req, 0);
        reset     = 1'b0;
        stray_ack = 1'b1;
      end
      if (k == 3) begin
        stray_ack = 1'b0;
        chk("stray_valid", id_valid, 0);
        chk("stray_instr", id_instr, 0);
        chk("stray_req", imem_req, 1);
        chk("stray_addr", imem_addr, 0);
      end
      if (k == 4) chk("stray_valid2", id_valid, 0);
    end
    chk("mrst_all_seen", exp_instr_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
